// File: rtl/adc_stream_scheduler.sv
// Round-robin burst scheduler that drives the one-hot select of the 16-way ADC stream mux.
// Grants one channel for a fixed number of handshaked beats, with a dead cycle between grants.
module adc_stream_scheduler #(
  parameter int NUM_CH         = 16,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              run,
  input  logic [NUM_CH-1:0] enable_mask,
  input  logic [CNT_W-1:0]  burst_len,
  input  logic [NUM_CH-1:0] ch_tvalid,
  input  logic              beat_valid,
  input  logic              beat_ready,
  output logic [NUM_CH-1:0] select_out,
  output logic [3:0]        grant_idx,
  output logic              busy,
  output logic              timeout_pulse,
  output logic [15:0]       timeout_count
);

  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ARB, XFER, GAP} state_t;

  state_t              state_q, state_d;
  logic [NUM_CH-1:0]   select_d;
  logic [3:0]          grant_d;
  logic                busy_d, pulse_d;
  logic [15:0]         tcount_d;
  logic [CNT_W-1:0]    len_q, len_d, beat_cnt_q, beat_cnt_d;
  logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;

  logic                hit;
  logic [3:0]          hit_idx, cand;
  logic                beat;

  assign beat = beat_valid & beat_ready;

  // Search starts one past the last grant so every requester gets a turn.
  always_comb begin
    hit     = 1'b0;
    hit_idx = grant_idx;
    cand    = grant_idx;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = grant_idx + 4'(k);
      if (!hit && enable_mask[cand] && ch_tvalid[cand]) begin
        hit     = 1'b1;
        hit_idx = cand;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    select_d   = select_out;
    grant_d    = grant_idx;
    pulse_d    = 1'b0;
    tcount_d   = timeout_count;
    len_d      = len_q;
    beat_cnt_d = beat_cnt_q;
    idle_cnt_d = idle_cnt_q;
    case (state_q)
      IDLE: begin
        select_d = '0;
        if (run && |enable_mask) state_d = ARB;
      end
      ARB: begin
        select_d = '0;
        if (!run) begin
          state_d = IDLE;
        end else if (hit) begin
          state_d    = XFER;
          select_d   = NUM_CH'(1) << hit_idx;
          grant_d    = hit_idx;
          len_d      = (burst_len == '0) ? CNT_W'(1) : burst_len;
          beat_cnt_d = '0;
          idle_cnt_d = '0;
        end
      end
      XFER: begin
        if (beat) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
          idle_cnt_d = '0;
          if (beat_cnt_q + CNT_W'(1) == len_q) begin
            state_d  = GAP;
            select_d = '0;
          end
        end else if (idle_cnt_q == IDLE_LAST) begin
          state_d  = GAP;
          select_d = '0;
          pulse_d  = 1'b1;
          if (timeout_count != 16'hFFFF) tcount_d = timeout_count + 16'd1;
        end else begin
          idle_cnt_d = idle_cnt_q + IDLE_W'(1);
        end
      end
      GAP: begin
        select_d = '0;
        state_d  = (run && |enable_mask) ? ARB : IDLE;
      end
      default: begin
        state_d  = IDLE;
        select_d = '0;
      end
    endcase
    busy_d = (state_d == XFER);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= IDLE;
      select_out    <= '0;
      grant_idx     <= 4'd15;
      busy          <= 1'b0;
      timeout_pulse <= 1'b0;
      timeout_count <= '0;
      len_q         <= CNT_W'(1);
      beat_cnt_q    <= '0;
      idle_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      select_out    <= select_d;
      grant_idx     <= grant_d;
      busy          <= busy_d;
      timeout_pulse <= pulse_d;
      timeout_count <= tcount_d;
      len_q         <= len_d;
      beat_cnt_q    <= beat_cnt_d;
      idle_cnt_q    <= idle_cnt_d;
    end
  end

endmodule

// File: tb/tb_adc_stream_scheduler.sv
// Directed bench for adc_stream_scheduler with a short timeout so timeouts are reachable.
module tb_adc_stream_scheduler;

  logic        clk = 1'b0;
  logic        resetn;
  logic        run;
  logic [15:0] enable_mask;
  logic [15:0] burst_len;
  logic [15:0] ch_tvalid;
  logic        beat_valid;
  logic        beat_ready;
  logic [15:0] select_out;
  logic [3:0]  grant_idx;
  logic        busy;
  logic        timeout_pulse;
  logic [15:0] timeout_count;

  int checks = 0;
  int passes = 0;

  adc_stream_scheduler #(.NUM_CH(16), .TIMEOUT_CYCLES(8), .CNT_W(16)) dut (
    .clk(clk), .resetn(resetn), .run(run), .enable_mask(enable_mask),
    .burst_len(burst_len), .ch_tvalid(ch_tvalid), .beat_valid(beat_valid),
    .beat_ready(beat_ready), .select_out(select_out), .grant_idx(grant_idx),
    .busy(busy), .timeout_pulse(timeout_pulse), .timeout_count(timeout_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance one cycle, then sample; select_out must stay one-hot or zero every cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    chk("onehot", 32'($countones(select_out) <= 1), 32'd1);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
  endtask

  task automatic chk_grant(input string tag, input int ch);
    chk({tag, "_sel"}, 32'(select_out), 32'(16'd1 << ch));
    chk({tag, "_idx"}, 32'(grant_idx), 32'(ch));
    chk({tag, "_busy"}, 32'(busy), 32'd1);
  endtask

  initial begin
    int order [6];
    order = '{0, 1, 15, 0, 1, 15};

    // Reset values
    run = 1'b1; enable_mask = 16'h0004; burst_len = 16'd4; ch_tvalid = 16'h0004;
    beat_valid = 1'b1; beat_ready = 1'b1;
    resetn = 1'b0;
    tick(); tick();
    chk("rst_sel", 32'(select_out), 32'h0);
    chk("rst_idx", 32'(grant_idx), 32'd15);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pulse", 32'(timeout_pulse), 32'd0);
    chk("rst_tcnt", 32'(timeout_count), 32'd0);
    resetn = 1'b1;

    // Single channel: IDLE->ARB, grant, 4 beats, GAP, ARB, re-grant
    tick();
    chk("s1_arb_sel", 32'(select_out), 32'h0);
    tick();
    chk_grant("s1_g1", 2);
    repeat (3) tick();
    chk("s1_beat4_sel", 32'(select_out), 32'h0004);
    tick();
    chk("s1_gap_sel", 32'(select_out), 32'h0);
    chk("s1_gap_busy", 32'(busy), 32'd0);
    tick();
    chk("s1_arb2_sel", 32'(select_out), 32'h0);
    tick();
    chk_grant("s1_g2", 2);

    // Round robin over 0,1,15 with two-beat bursts
    enable_mask = 16'h8003; ch_tvalid = 16'hFFFF; burst_len = 16'd2;
    do_reset();
    tick();
    for (int g = 0; g < 6; g++) begin
      tick();
      chk_grant("rr_b1", order[g]);
      tick();
      chk("rr_b2_sel", 32'(select_out), 32'(16'd1 << order[g]));
      tick();
      chk("rr_gap_sel", 32'(select_out), 32'h0);
      tick();
      chk("rr_arb_sel", 32'(select_out), 32'h0);
    end

    // Masking and zero burst length: only ch4, one beat per grant
    enable_mask = 16'h0010; burst_len = 16'd0; ch_tvalid = 16'hFFFF;
    do_reset();
    tick(); tick();
    chk_grant("m_g1", 4);
    tick();
    chk("m_gap_sel", 32'(select_out), 32'h0);
    tick(); tick();
    chk_grant("m_g2", 4);
    enable_mask = 16'h0000; beat_valid = 1'b0;
    tick();
    chk("m_hold_sel", 32'(select_out), 32'h0010);
    beat_valid = 1'b1;
    tick();
    chk("m_done_sel", 32'(select_out), 32'h0);
    chk("m_done_busy", 32'(busy), 32'd0);
    tick(); tick();
    chk("m_idle_sel", 32'(select_out), 32'h0);
    chk("m_idle_busy", 32'(busy), 32'd0);

    // Timeout on ch3 after 8 idle cycles, then ch5; a beat on cycle 8 suppresses
    enable_mask = 16'h0028; burst_len = 16'd4; ch_tvalid = 16'hFFFF; beat_valid = 1'b0;
    do_reset();
    tick(); tick();
    chk_grant("to_g3", 3);
    repeat (7) tick();
    chk("to_pre_sel", 32'(select_out), 32'h0008);
    chk("to_pre_pulse", 32'(timeout_pulse), 32'd0);
    tick();
    chk("to_sel", 32'(select_out), 32'h0);
    chk("to_pulse", 32'(timeout_pulse), 32'd1);
    chk("to_cnt", 32'(timeout_count), 32'd1);
    chk("to_busy", 32'(busy), 32'd0);
    tick();
    chk("to_pulse_end", 32'(timeout_pulse), 32'd0);
    tick();
    chk_grant("to_g5", 5);
    repeat (7) tick();
    beat_valid = 1'b1;
    tick();
    beat_valid = 1'b0;
    chk("sup_sel", 32'(select_out), 32'h0020);
    chk("sup_pulse", 32'(timeout_pulse), 32'd0);
    chk("sup_cnt", 32'(timeout_count), 32'd1);

    // Backpressure with run dropped after beat 2: 5 beats across 9 cycles
    enable_mask = 16'h0002; ch_tvalid = 16'h0002; burst_len = 16'd5;
    beat_valid = 1'b1; run = 1'b1;
    do_reset();
    tick(); tick();
    for (int c = 0; c < 9; c++) begin
      beat_ready = (c % 2 == 0);
      run = (c < 3);
      chk("bp_sel", 32'(select_out), 32'h0002);
      tick();
    end
    beat_ready = 1'b1;
    chk("bp_gap_sel", 32'(select_out), 32'h0);
    chk("bp_gap_busy", 32'(busy), 32'd0);
    tick(); tick();
    chk("bp_idle_sel", 32'(select_out), 32'h0);
    chk("bp_idle_busy", 32'(busy), 32'd0);

    // Reset mid-burst after a timeout has been counted
    run = 1'b1; enable_mask = 16'h0041; ch_tvalid = 16'h0040; burst_len = 16'd3;
    beat_valid = 1'b0;
    do_reset();
    tick(); tick();
    chk_grant("rm_g6", 6);
    repeat (8) tick();
    chk("rm_to_cnt", 32'(timeout_count), 32'd1);
    tick(); tick();
    chk_grant("rm_g6b", 6);
    beat_valid = 1'b1;
    tick();
    chk("rm_mid_sel", 32'(select_out), 32'h0040);
    resetn = 1'b0;
    ch_tvalid = 16'h0041;
    tick();
    chk("rm_sel", 32'(select_out), 32'h0);
    chk("rm_busy", 32'(busy), 32'd0);
    chk("rm_idx", 32'(grant_idx), 32'd15);
    chk("rm_tcnt", 32'(timeout_count), 32'd0);
    resetn = 1'b1;
    tick(); tick();
    chk_grant("rm_first", 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/adc_stream_scheduler.md
Name: adc_stream_scheduler

Overview:
Round-robin scheduler that drives the one-hot select input of the 16-way ADC AXI-Stream mux. It grants one ADC driver at a time for a fixed burst of beats. It counts completed beats by monitoring the mux master-side handshake, then moves to the next enabled channel that has valid data. It sits between the PS-facing configuration registers and the mux. It guarantees that at most one select bit is ever high and that there is always a dead cycle between grants.

Parameters:
NUM_CH, 16, number of mux inputs; fixed to 16 to match the mux
TIMEOUT_CYCLES, 1024, consecutive cycles without a beat before an active grant is aborted
CNT_W, 16, width of the burst length and beat counter

Ports:
clk  input  1  system clock; the block has one clock
resetn  input  1  synchronous, active-low reset
run  input  1  level; 1 = scheduler active
enable_mask  input  16  per-channel enable; bit i = ADC driver i may be granted
burst_len  input  CNT_W  beats per grant; latched at grant time; 0 is treated as 1
ch_tvalid  input  16  copy of the per-channel s_axis_tvalid bits seen by the mux
beat_valid  input  1  mux m_axis_tvalid
beat_ready  input  1  mux m_axis_tready
select_out  output  16  one-hot select to the mux; all-zero = nothing selected
grant_idx  output  4  index of the current or last granted channel
busy  output  1  1 while in the XFER state
timeout_pulse  output  1  single-cycle pulse when a grant is aborted by timeout
timeout_count  output  16  saturating count of timeouts; cleared only by reset

Behaviour:
- All outputs are registered.
- Reset (resetn=0 at a clk edge) values: state=IDLE, select_out=0, grant_idx=15 (so the first search starts at channel 0), busy=0, timeout_pulse=0, timeout_count=0, beat counter=0, idle counter=0.
- Reset asserted mid-burst: select_out drops to 0 on the same edge. No burst completion is required.
- States: IDLE, ARB, XFER, GAP.
- IDLE: select_out=0.
  - Go to ARB when run=1 and enable_mask is non-zero.
- ARB: search channels grant_idx+1 .. grant_idx+16, modulo 16, for the first i with enable_mask[i] & ch_tvalid[i].
  - Hit: on the next edge, select_out=1<<i, grant_idx=i, latch burst_len (0 becomes 1), beat_cnt=0, idle_cnt=0, state=XFER.
  - No hit: stay in ARB with select_out=0.
  - run=0: go to IDLE.
  - Arbitration latency is one cycle from a qualifying ch_tvalid to select_out asserting.
- XFER: busy=1.
  - A beat is a cycle with beat_valid & beat_ready.
  - Each beat increments beat_cnt and clears idle_cnt. Each non-beat cycle increments idle_cnt.
  - The beat that brings beat_cnt to the latched burst length moves the state to GAP. select_out is 0 in the following cycle, so exactly burst_len beats pass.
  - If idle_cnt reaches TIMEOUT_CYCLES-1 with no beat: go to GAP, pulse timeout_pulse for one cycle, increment timeout_count (saturating at 0xFFFF).
  - A beat and the timeout threshold in the same cycle: the beat wins and there is no timeout.
  - run deasserting, or the granted enable_mask bit clearing, mid-burst does not truncate the burst. It completes or times out normally.
  - Changes to burst_len during XFER have no effect on the current burst.
- GAP: exactly one cycle with select_out=0 (break-before-make between channels).
  - Next state is ARB if run=1 and enable_mask is non-zero, else IDLE.
- Fairness: the search always starts after the last granted index. A lone requesting channel is re-granted after ARB+GAP.
- select_out must never have more than one bit set. This is an assertion in the bench.

Test Plan:
- Single channel: run=1, enable_mask=0x0004, ch_tvalid[2]=1, burst_len=4, beat_ready=1 -> select_out=0x0004 one cycle after ARB. It drops after exactly 4 beats, then one GAP cycle, then ARB and a re-grant of ch2. grant_idx=2.
- Round robin: enable_mask=0x8003, all ch_tvalid high, burst_len=2 -> grant order 0,1,15,0,1,15. Two beats per grant. select_out=0 for one cycle between grants.
- Masking/zero length: enable_mask=0x0010, burst_len=0, ch_tvalid=0xFFFF -> only ch4 is ever granted, one beat per grant. Clearing enable_mask[4] mid-burst still completes the burst, then the block goes to IDLE.
- Timeout: TIMEOUT_CYCLES=8, grant ch3, beat_valid held 0 -> after 8 idle cycles timeout_pulse is high for 1 cycle, timeout_count=1, and the scheduler moves to the next channel. A beat landing on cycle 8 suppresses the timeout.
- Backpressure/run drop: burst_len=5, beat_ready toggling 1010…, run deasserted after beat 2 -> all 5 beats are accepted, then GAP, then IDLE with select_out=0.
- Reset mid-burst: resetn=0 during XFER -> next edge gives select_out=0, busy=0, grant_idx=15, timeout_count=0. After release, the first grant goes to the lowest enabled valid channel.
